// File: rtl/axi_window_mapper_if.sv
// -----------------------------------------------------------------------------
// axi_window_mapper_if
// Five-channel AXI4 bundle (AW, W, B, AR, R) used on both sides of
// axi_window_mapper.
//   master modport : drives requests (AW/W/AR) and B/R ready, receives the rest
//   slave  modport : receives requests, drives responses and AW/W/AR ready
// -----------------------------------------------------------------------------
interface axi_window_mapper_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 8,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0]   awaddr;
    logic [ID_W-1:0]     awid;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ADDR_W-1:0]   araddr;
    logic [ID_W-1:0]     arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [ID_W-1:0]     rid;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awid, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input  bid, bresp, bvalid, output bready,
        output araddr, arid, arlen, arsize, arburst, arvalid, input arready,
        input  rdata, rid, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input  awaddr, awid, awlen, awsize, awburst, awvalid, output awready,
        input  wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input  araddr, arid, arlen, arsize, arburst, arvalid, output arready,
        output rdata, rid, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_window_mapper.sv
// -----------------------------------------------------------------------------
// axi_window_mapper
// AXI4 address window mapper with a DECERR responder. Each AW/AR address is
// decoded against NWIN windows (lowest index wins) and rewritten into the
// window's target region. Unmapped requests are absorbed locally and answered
// with DECERR, ordered behind all outstanding mapped traffic.
//   uncoreclk    : clock
//   uncorerst    : synchronous active-high reset
//   s_axi        : upstream port (from the bus master)
//   m_axi        : downstream port (to the DDR slave)
//   dec_err_cnt  : saturating count of DECERR transactions
// -----------------------------------------------------------------------------
module axi_window_mapper #(
    parameter int                     ADDR_W   = 32,
    parameter int                     ID_W     = 8,
    parameter int                     DATA_W   = 64,
    parameter int                     NWIN     = 4,
    parameter logic [NWIN*ADDR_W-1:0] WIN_BASE = '0,
    parameter logic [NWIN*ADDR_W-1:0] WIN_MASK = '1,
    parameter logic [NWIN*ADDR_W-1:0] WIN_TGT  = '0,
    parameter int                     MAX_OUT  = 8,
    parameter int                     WQ_DEPTH = 4
) (
    input  logic                 uncoreclk,
    input  logic                 uncorerst,
    axi_window_mapper_if.slave   s_axi,
    axi_window_mapper_if.master  m_axi,
    output logic [15:0]          dec_err_cnt
);
    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int QW = $clog2(WQ_DEPTH);

    typedef struct packed {
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } req_t;

    typedef enum logic [1:0] {WE_IDLE, WE_DRAIN, WE_WAIT, WE_RESP} we_state_t;
    typedef enum logic [1:0] {RE_IDLE, RE_WAIT, RE_RESP} re_state_t;

    // Scanning from the top down lets the lowest matching window overwrite
    // any higher match.
    function automatic req_t map_req(input logic [ADDR_W-1:0] addr, input logic [ID_W-1:0] id,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
        req_t r;
        r.err   = 1'b1;
        r.addr  = addr;
        r.id    = id;
        r.len   = len;
        r.size  = size;
        r.burst = burst;
        for (int i = NWIN - 1; i >= 0; i--) begin
            if ((addr & WIN_MASK[i*ADDR_W +: ADDR_W]) == WIN_BASE[i*ADDR_W +: ADDR_W]) begin
                r.err  = 1'b0;
                r.addr = WIN_TGT[i*ADDR_W +: ADDR_W] | (addr & ~WIN_MASK[i*ADDR_W +: ADDR_W]);
            end
        end
        return r;
    endfunction

    logic              aw_full, ar_full;
    req_t              aw_q, ar_q;
    logic [CW-1:0]     wr_out, rd_out;
    logic [WQ_DEPTH-1:0] rq_mem;
    logic [QW:0]       rq_wp, rq_rp;
    we_state_t         we_state, we_next;
    re_state_t         re_state, re_next;
    logic [ID_W-1:0]   err_bid, err_rid;
    logic [7:0]        err_rlen, err_beat;

    // ---------------- AW slot and handoff ----------------
    logic rq_empty, rq_full, rq_head, rq_pop;
    logic aw_map_go, aw_map_hs, aw_err_go, aw_pop, aw_acc;
    logic b_map_hs;

    // The gating terms only move toward "allowed" while the slot waits,
    // so awvalid never drops before its handshake.
    assign aw_map_go = aw_full && !aw_q.err && (wr_out < CW'(MAX_OUT)) && !rq_full
                       && (we_state == WE_IDLE);
    assign aw_err_go = aw_full && aw_q.err && !rq_full && (we_state == WE_IDLE);
    assign aw_map_hs = aw_map_go && m_axi.awready;
    assign aw_pop    = aw_map_hs || aw_err_go;
    assign aw_acc    = s_axi.awvalid && s_axi.awready;

    assign s_axi.awready  = !aw_full || aw_pop;
    assign m_axi.awvalid  = aw_map_go;
    assign m_axi.awaddr   = aw_q.addr;
    assign m_axi.awid     = aw_q.id;
    assign m_axi.awlen    = aw_q.len;
    assign m_axi.awsize   = aw_q.size;
    assign m_axi.awburst  = aw_q.burst;

    // ---------------- AR slot and handoff ----------------
    logic ar_map_go, ar_map_hs, ar_err_go, ar_pop, ar_acc;
    logic r_map_last_hs;

    assign ar_map_go = ar_full && !ar_q.err && (rd_out < CW'(MAX_OUT)) && (re_state == RE_IDLE);
    assign ar_err_go = ar_full && ar_q.err && (re_state == RE_IDLE);
    assign ar_map_hs = ar_map_go && m_axi.arready;
    assign ar_pop    = ar_map_hs || ar_err_go;
    assign ar_acc    = s_axi.arvalid && s_axi.arready;

    assign s_axi.arready  = !ar_full || ar_pop;
    assign m_axi.arvalid  = ar_map_go;
    assign m_axi.araddr   = ar_q.addr;
    assign m_axi.arid     = ar_q.id;
    assign m_axi.arlen    = ar_q.len;
    assign m_axi.arsize   = ar_q.size;
    assign m_axi.arburst  = ar_q.burst;

    // ---------------- W routing (route FIFO head: 0 = slave, 1 = discard) ----
    assign rq_empty = (rq_wp == rq_rp);
    assign rq_full  = (rq_wp[QW] != rq_rp[QW]) && (rq_wp[QW-1:0] == rq_rp[QW-1:0]);
    assign rq_head  = rq_mem[rq_rp[QW-1:0]];
    assign rq_pop   = s_axi.wvalid && s_axi.wready && s_axi.wlast;

    assign m_axi.wvalid = !rq_empty && !rq_head && s_axi.wvalid;
    assign m_axi.wdata  = s_axi.wdata;
    assign m_axi.wstrb  = s_axi.wstrb;
    assign m_axi.wlast  = s_axi.wlast;
    assign s_axi.wready = !rq_empty && (rq_head || m_axi.wready);

    // ---------------- B / R response muxing ----------------
    logic we_resp, re_resp, err_last;
    assign we_resp  = (we_state == WE_RESP);
    assign re_resp  = (re_state == RE_RESP);
    assign err_last = (err_beat == err_rlen);

    assign s_axi.bvalid = we_resp ? 1'b1    : m_axi.bvalid;
    assign s_axi.bresp  = we_resp ? 2'b11   : m_axi.bresp;
    assign s_axi.bid    = we_resp ? err_bid : m_axi.bid;
    assign m_axi.bready = !we_resp && s_axi.bready;
    assign b_map_hs     = m_axi.bvalid && m_axi.bready;

    assign s_axi.rvalid = re_resp ? 1'b1     : m_axi.rvalid;
    assign s_axi.rdata  = re_resp ? '0       : m_axi.rdata;
    assign s_axi.rresp  = re_resp ? 2'b11    : m_axi.rresp;
    assign s_axi.rid    = re_resp ? err_rid  : m_axi.rid;
    assign s_axi.rlast  = re_resp ? err_last : m_axi.rlast;
    assign m_axi.rready = !re_resp && s_axi.rready;
    assign r_map_last_hs = m_axi.rvalid && m_axi.rready && m_axi.rlast;

    // ---------------- Error FSMs: next state ----------------
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        we_next = we_state;
        unique case (we_state)
            WE_IDLE:  if (aw_err_go) we_next = WE_DRAIN;
            // wr_out cannot rise here: mapped AW handoff is held off outside WE_IDLE.
            WE_DRAIN: if (rq_pop && rq_head) we_next = (wr_out == '0) ? WE_RESP : WE_WAIT;
            WE_WAIT:  if (wr_out == '0) we_next = WE_RESP;
            WE_RESP:  if (s_axi.bready) we_next = WE_IDLE;
            default:  we_next = WE_IDLE;
        endcase
    end

    always_comb begin
        re_next = re_state;
        unique case (re_state)
            RE_IDLE: if (ar_err_go) re_next = RE_WAIT;
            RE_WAIT: if (rd_out == '0) re_next = RE_RESP;
            RE_RESP: if (s_axi.rready && err_last) re_next = RE_IDLE;
            default: re_next = RE_IDLE;
        endcase
    end

    // ---------------- Control registers ----------------
    logic [1:0]  err_inc;
    logic [16:0] err_sum;
    assign err_inc = {1'b0, aw_err_go} + {1'b0, ar_err_go};
    assign err_sum = {1'b0, dec_err_cnt} + 17'(err_inc);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            aw_full     <= 1'b0;
            ar_full     <= 1'b0;
            wr_out      <= '0;
            rd_out      <= '0;
            rq_wp       <= '0;
            rq_rp       <= '0;
            we_state    <= WE_IDLE;
            re_state    <= RE_IDLE;
            dec_err_cnt <= '0;
        end else begin
            if (aw_acc)      aw_full <= 1'b1;
            else if (aw_pop) aw_full <= 1'b0;
            if (ar_acc)      ar_full <= 1'b1;
            else if (ar_pop) ar_full <= 1'b0;

            case ({aw_map_hs, b_map_hs})
                2'b10:   wr_out <= wr_out + CW'(1);
                2'b01:   wr_out <= wr_out - CW'(1);
                default: ;
            endcase
            case ({ar_map_hs, r_map_last_hs})
                2'b10:   rd_out <= rd_out + CW'(1);
                2'b01:   rd_out <= rd_out - CW'(1);
                default: ;
            endcase

            if (aw_pop) rq_wp <= rq_wp + (QW+1)'(1);
            if (rq_pop) rq_rp <= rq_rp + (QW+1)'(1);

            we_state    <= we_next;
            re_state    <= re_next;
            dec_err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    // ---------------- Datapath registers ----------------
    // NOTE: payload and FIFO storage carry no reset; they are only read while
    // the matching valid flag / pointer pair says they hold live data.
    always_ff @(posedge uncoreclk) begin
        if (aw_acc) aw_q <= map_req(s_axi.awaddr, s_axi.awid, s_axi.awlen, s_axi.awsize, s_axi.awburst);
        if (ar_acc) ar_q <= map_req(s_axi.araddr, s_axi.arid, s_axi.arlen, s_axi.arsize, s_axi.arburst);
        if (aw_pop) rq_mem[rq_wp[QW-1:0]] <= aw_err_go;
        if (aw_err_go) err_bid <= aw_q.id;
        if (ar_err_go) begin
            err_rid  <= ar_q.id;
            err_rlen <= ar_q.len;
            err_beat <= '0;
        end else if (re_resp && s_axi.rready) begin
            err_beat <= err_beat + 8'd1;
        end
    end
endmodule

// File: doc/axi_window_mapper.md
# axi_window_mapper

Parametrised AXI4 address window mapper and decode-error responder placed between a bus master (core `AXI_MEM` port) and the PS DDR slave. It decodes each AW/AR address against `NWIN` windows and rewrites the address into that window's target region. Unmapped requests never reach the slave: the block absorbs them and answers with DECERR, in AXI order. The block adds one register stage on AW and AR, and bounds the number of outstanding transactions.

## Interface
- `ADDR_W`, 32, address width
- `ID_W`, 8, AXI ID width
- `DATA_W`, 64, data width; `wstrb` is `DATA_W/8`
- `NWIN`, 4, number of windows (1..8)
- `WIN_BASE`, `NWIN*ADDR_W` packed, match value of window i in slice i
- `WIN_MASK`, `NWIN*ADDR_W` packed, window i matches when `(addr & mask_i) == base_i`
- `WIN_TGT`, `NWIN*ADDR_W` packed, output address is `tgt_i | (addr & ~mask_i)`
- `MAX_OUT`, 8, maximum outstanding mapped transactions per direction (power of 2)
- `WQ_DEPTH`, 4, depth of the W-route FIFO (power of 2)

Ports:
- `uncoreclk`  in  1  sole clock
- `uncorerst`  in  1  synchronous, active-high reset
- `s_axi_aw{addr,id,len,size,burst,valid}`  in, `s_axi_awready` out: slave-side AW
- `s_axi_w{data,strb,last,valid}`  in, `s_axi_wready` out
- `s_axi_b{id,resp,valid}`  out, `s_axi_bready` in
- `s_axi_ar{addr,id,len,size,burst,valid}`  in, `s_axi_arready` out
- `s_axi_r{data,id,resp,last,valid}`  out, `s_axi_rready` in
- `m_axi_*`: mirror set of the five channels, facing the DDR slave
- `dec_err_cnt`  out  16  saturating count of DECERR transactions

## Operation
- Decode: lowest matching window index wins. No match means the request is an error.
- AW/AR slice: single-entry register per direction that holds the translated address, the error flag, and all pass-through fields. Accepts a new request when the slot is empty or is being handed off in the same cycle.
- Mapped AW handoff: the slot presents `m_axi_awvalid`. Handoff requires `wr_out < MAX_OUT`, a non-full route FIFO, and no pending write error. On handshake: `wr_out++` and push route=0.
- Error AW handoff: requires a non-full route FIFO. Push route=1 and enter write error state `WE_DRAIN`.
- W routing: the head of the route FIFO selects the destination.
  - route=0: W is connected combinationally to `m_axi_w*`.
  - route=1: `s_axi_wready=1` and beats are discarded.
  - On the `wlast` handshake, pop the FIFO. If the FIFO is empty, `s_axi_wready=0`.
- Write error FSM:
  - `WE_IDLE`
  - `WE_DRAIN`: wait for the discarded `wlast`.
  - `WE_WAIT`: wait for `wr_out==0`.
  - `WE_RESP`: drive `s_axi_bvalid=1`, `bresp=2'b11`, latched `bid`. Return to `WE_IDLE` on `bready`.
  - In every state except `WE_RESP`, B passes through from the master side.
- Read error FSM:
  - `RE_IDLE`
  - `RE_WAIT`: wait for `rd_out==0`.
  - `RE_RESP`: emit `len+1` beats with `rdata=0`, `rresp=2'b11`, latched `rid`, and `rlast` on the final beat. Beats advance on `rready`.
  - The AR slot is blocked while `RE` is not `RE_IDLE`.
- Counters: `wr_out`/`rd_out` are `log2(MAX_OUT)+1` bits. Increment on m-side AW/AR handshake. Decrement on B handshake, or on R handshake with `rlast`. If both happen in one cycle, the count is unchanged.
- `dec_err_cnt`: increments once per error AW or AR slot handoff and holds at `0xFFFF`. If both directions hand off an error in the same cycle, it adds 2, saturating.

## Timing
- Reset values: all `*valid` outputs 0, all slots empty, route FIFO empty, counters 0, both FSMs idle, `dec_err_cnt=0`. Ready outputs reflect the empty state in the first cycle after reset: `s_axi_awready=s_axi_arready=1`, `s_axi_wready=0`.
- AW/AR latency: request accepted in cycle N gives `m_axi_*valid` in N+1 at the earliest. Sustained throughput is 1 request/cycle.
- W, B and R pass-through are combinational, with 0 added latency.
- Error B appears at the earliest one cycle after the later of the discarded `wlast` and `wr_out` reaching 0.
- Error R first beat appears one cycle after `rd_out` reaches 0.
- Valid/ready rule: once asserted, a `valid` and its payload hold until handshake. No output `valid` depends combinationally on the same channel's `ready`.
- Reset asserted mid-burst returns every register to its reset value on the next edge. No partial response is completed.

## Test plan
- Window 0 set to base 0x0000_0000, mask 0xF000_0000, tgt 0x1000_0000. AR to 0x0000_1000 with len=3 → `m_axi_araddr=0x1000_1000` one cycle later, and 4 R beats pass through unchanged.
- AW/W to unmapped 0xF000_0000 with len=1 → no `m_axi_awvalid`, both W beats accepted, B returns `bresp=2'b11` with the original `bid`, and `dec_err_cnt=1`.
- Mapped AR with len=7, then an unmapped AR with the same ID → the error R beats start only after the mapped `rlast`, giving 1 beat with `rresp=3`, `rlast=1`.
- Issue 9 mapped AWs with B held off (`MAX_OUT=8`) → the 9th stalls on `m_axi_awvalid` until one B handshakes.
- Overlapping windows 0 and 1, address inside both → window 0's target is used.
- Assert reset in the middle of an error read burst → next cycle `s_axi_rvalid=0`, the FSM is idle, and a new AR is accepted.
